// File: rtl/mask_modulator.sv
// M-ary ASK modulator: phase-accumulator carrier, sine LUT and per-symbol gain, two-stage output pipeline.
// Define ASK_RAMP_EN to slew the gain toward each level by RAMP_STEP per sample instead of stepping.
module mask_modulator #(
  parameter int OUT_W           = 16,
  parameter int BITS_PER_SYM    = 2,
  parameter int SAMPLES_PER_SYM = 16,
  parameter int PHASE_W         = 12,
  parameter int LUT_AW          = 8,
  parameter int GAIN_W          = 8,
  parameter int RAMP_STEP       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PHASE_W-1:0]      fcw,
  input  logic                    sym_valid,
  input  logic [BITS_PER_SYM-1:0] sym_data,
  output logic                    sym_ready,
  output logic signed [OUT_W-1:0] out,
  output logic                    out_valid,
  output logic                    underrun
);

  localparam int M      = 1 << BITS_PER_SYM;
  localparam int LUT_N  = 1 << LUT_AW;
  localparam int CNT_W  = (SAMPLES_PER_SYM > 2) ? $clog2(SAMPLES_PER_SYM) : 1;
  localparam int GW     = GAIN_W + 1;
  localparam int PROD_W = OUT_W + GW + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYM - 1);
`ifdef ASK_RAMP_EN
  localparam logic [GW-1:0] STEP = GW'((RAMP_STEP > (1 << GAIN_W)) ? (1 << GAIN_W) : RAMP_STEP);
`endif

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic int sine_val(input int idx);
    real amp;
    real a;
    amp = real'((1 << (OUT_W - 1)) - 1);
    a = amp * $sin(2.0 * 3.14159265358979 * real'(idx) / real'(LUT_N));
    if (a >= 0.0) return $rtoi(a + 0.5);
    return -$rtoi(0.5 - a);
  endfunction

  function automatic int gain_val(input int k);
    return (2 * k * (1 << GAIN_W) + (M - 1)) / (2 * (M - 1));
  endfunction

  logic signed [OUT_W-1:0] sine_lut [LUT_N];
  logic [GW-1:0]           gain_lut [M];

  for (genvar i = 0; i < LUT_N; i++) begin : g_sine
    localparam int V = sine_val(i);
    assign sine_lut[i] = OUT_W'(V);
  end

  for (genvar k = 0; k < M; k++) begin : g_gain
    localparam int G = gain_val(k);
    assign gain_lut[k] = GW'(G);
  end

  if (SAMPLES_PER_SYM < 2 || RAMP_STEP < 1) begin : g_cfg_check
    $error("mask_modulator: SAMPLES_PER_SYM must be >= 2 and RAMP_STEP >= 1");
  end

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [BITS_PER_SYM-1:0] k_q, k_d;
  logic signed [OUT_W-1:0] sine_q, sine_d;
  logic [GW-1:0]           gain_q, gain_d, target;
  logic                    stage_valid_q, stage_valid_d;
  logic signed [OUT_W-1:0] out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    underrun_q, underrun_d;
  logic                    last, xfer;
  logic signed [PROD_W-1:0] prod;

  assign last      = (cnt_q == LAST_CNT);
  assign sym_ready = enable & ~reset & ((state_q == IDLE) | last);
  assign xfer      = sym_valid & sym_ready;
  assign prod      = PROD_W'(sine_q) * PROD_W'($signed({1'b0, gain_q}));

  // Stage 1 captures sine and gain for the next state, so a symbol accepted now reaches out two cycles later.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    k_d           = k_q;
    sine_d        = sine_q;
    gain_d        = gain_q;
    stage_valid_d = stage_valid_q;
    out_d         = out_q;
    out_valid_d   = out_valid_q;
    underrun_d    = 1'b0;
    target        = '0;
    if (enable) begin
      phase_d = phase_q + fcw;
      if (xfer) begin
        state_d = ACTIVE;
        k_d     = sym_data;
        cnt_d   = '0;
      end else if (state_q == ACTIVE) begin
        if (last) begin
          state_d    = IDLE;
          cnt_d      = '0;
          underrun_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      stage_valid_d = (state_d == ACTIVE);
      target        = stage_valid_d ? gain_lut[k_d] : '0;
`ifdef ASK_RAMP_EN
      if (gain_q < target)
        gain_d = ((target - gain_q) > STEP) ? gain_q + STEP : target;
      else if (gain_q > target)
        gain_d = ((gain_q - target) > STEP) ? gain_q - STEP : target;
`else
      gain_d = target;
`endif
      sine_d      = sine_lut[phase_q[PHASE_W-1 -: LUT_AW]];
      out_d       = OUT_W'(prod >>> GAIN_W);
      out_valid_d = stage_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      phase_q       <= '0;
      k_q           <= '0;
      sine_q        <= '0;
      gain_q        <= '0;
      stage_valid_q <= 1'b0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      k_q           <= k_d;
      sine_q        <= sine_d;
      gain_q        <= gain_d;
      stage_valid_q <= stage_valid_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      underrun_q    <= underrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule
